// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART block: parity mode encodings, the
//   transmit and receive state enumerations, and the parity helper that
//   both directions use so they always agree on the parity rule.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Callers zero-extend narrower payloads to 8 bits; the extra zeros
   // do not change the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx
//   Serial receiver with a 2-flop input synchroniser, mid-bit sampling,
//   false-start rejection, parity and framing checks, break handling and
//   a one-entry output holding register with sticky overrun.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   rxd_i           : serial line, asynchronous, idle high
//   rx_data_o       : held payload
//   rx_valid_o      : holding register full
//   rx_ready_i      : consumer accepts the held payload
//   rx_parity_err_o : parity mismatch on the held payload
//   rx_frame_err_o  : stop bit sampled low on the held payload
//   rx_overrun_o    : a payload was dropped since the last accept
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 rx_parity_err_o,
   output logic                 rx_frame_err_o,
   output logic                 rx_overrun_o
);

   localparam int            TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

   logic sync1_q, sync2_q;
   logic rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 done, done_perr, done_ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RX_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

   // The timer restarts at every sample point, so the first data sample
   // lands a full bit after the mid-start sample, i.e. mid-bit as well.
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      done      = 1'b0;
      done_perr = 1'b0;
      done_ferr = 1'b0;
      timer_d   = '0;
      if (state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
         timer_d = timer_q + 1'b1;
      end

      unique case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (timer_q == HALF_TICK) begin
               timer_d = '0;
               bit_d   = '0;
               // Line back high by mid-start: a glitch, not a frame.
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (timer_q == LAST_TICK) begin
               timer_d = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
               end
            end
         end
         RX_PARITY: begin
            if (timer_q == LAST_TICK) begin
               timer_d = '0;
               par_d   = rx_s;
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (timer_q == LAST_TICK) begin
               timer_d   = '0;
               done      = 1'b1;
               done_ferr = !rx_s;
               done_perr = (PARITY != PARITY_NONE) &&
                           (par_q != parity_bit(8'(shift_q), PARITY));
               // A low stop bit may be a break; wait for the line to
               // recover so a held-low line yields exactly one frame.
               state_d   = rx_s ? RX_IDLE : RX_BREAK;
            end
         end
         RX_BREAK: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   // An accept and a new payload on the same edge keep valid high with
   // the new payload; a payload with nowhere to go is dropped.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      accept  = valid_q & rx_ready_i;
      if (accept) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (done) begin
         if (!valid_q || rx_ready_i) begin
            data_d  = shift_q;
            perr_d  = done_perr;
            ferr_d  = done_ferr;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign rx_data_o       = data_q;
   assign rx_valid_o      = valid_q;
   assign rx_parity_err_o = perr_q;
   assign rx_frame_err_o  = ferr_q;
   assign rx_overrun_o    = ovr_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   Serial transmitter: start bit, DATA_BITS payload bits LSB first,
//   optional parity bit, STOP_BITS stop bits, each CLKS_PER_BIT cycles.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   tx_data_i    : payload, captured on the valid/ready handshake
//   tx_valid_i   : payload valid
//   tx_ready_o   : high while idle, i.e. able to accept a payload
//   txd_o        : serial line, idle high, driven straight from a flop
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 txd_o
);

   localparam int            TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   tx_state_e            state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [2:0]           bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 line_q, line_d;
   logic                 tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         line_q  <= line_d;
      end
   end

   // line_d is the level the pin shows during the state being entered,
   // so the pin is a plain register output and never glitches.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      line_d  = line_q;
      tick    = (timer_q == LAST_TICK);
      timer_d = '0;
      if (state_q != TX_IDLE && !tick) begin
         timer_d = timer_q + 1'b1;
      end

      unique case (state_q)
         TX_IDLE: begin
            if (tx_valid_i) begin
               shift_d = tx_data_i;
               par_d   = parity_bit(8'(tx_data_i), PARITY);
               line_d  = 1'b0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (tick) begin
               bit_d   = '0;
               line_d  = shift_q[0];
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  if (PARITY != PARITY_NONE) begin
                     line_d  = par_q;
                     state_d = TX_PARITY;
                  end else begin
                     stop_d  = 1'b0;
                     line_d  = 1'b1;
                     state_d = TX_STOP;
                  end
               end else begin
                  line_d = shift_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (tick) begin
               stop_d  = 1'b0;
               line_d  = 1'b1;
               state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (stop_q == LAST_STOP) begin
                  state_d = TX_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            line_d  = 1'b1;
            state_d = TX_IDLE;
         end
      endcase
   end

   assign tx_ready_o = (state_q == TX_IDLE);
   assign txd_o      = line_q;

endmodule

// File: rtl/uart_core.sv
// uart_core
//   Full-duplex UART: independent transmitter and receiver behind
//   valid/ready byte streams, with configurable data width, parity and
//   stop-bit count.
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   uart_rx       : serial input pin, asynchronous, idle high
//   uart_tx       : serial output pin, idle high
//   tx_data/valid/ready : transmit byte stream, LSB sent first
//   rx_data/valid/ready : receive byte stream
//   rx_parity_err, rx_frame_err : error flags qualified by rx_valid
//   rx_overrun    : sticky, a byte was dropped since the last accept
module uart_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_core: CLKS_PER_BIT=%0d outside 8..65535", CLKS_PER_BIT);
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_core: DATA_BITS=%0d outside 5..8", DATA_BITS);
   end
   if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_par
      $error("uart_core: PARITY=%0d not 0, 1 or 2", PARITY);
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_core: STOP_BITS=%0d not 1 or 2", STOP_BITS);
   end

   // Reset asserts asynchronously (uart_tx goes high at once) but is
   // released in step with clk so no flop sees a release near an edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_BITS    (DATA_BITS),
      .PARITY       (PARITY),
      .STOP_BITS    (STOP_BITS)
   ) u_tx (
      .clk        (clk),
      .rst_n      (rst_n_int),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .txd_o      (uart_tx)
   );

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_BITS    (DATA_BITS),
      .PARITY       (PARITY)
   ) u_rx (
      .clk             (clk),
      .rst_n           (rst_n_int),
      .rxd_i           (uart_rx),
      .rx_data_o       (rx_data),
      .rx_valid_o      (rx_valid),
      .rx_ready_i      (rx_ready),
      .rx_parity_err_o (rx_parity_err),
      .rx_frame_err_o  (rx_frame_err),
      .rx_overrun_o    (rx_overrun)
   );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core
//   Directed bench for uart_core. Three instances at 16 clocks per bit:
//   dut_n (8N1), dut_e (8E1, receive side) and dut_l (7O2, tx looped
//   back to rx).
module tb_uart_core;

   localparam int CPB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [7:0] tx_data_n, rx_data_n;
   logic       tx_valid_n, tx_ready_n, uart_tx_n, rx_n, rx_valid_n, rx_ready_n;
   logic       perr_n, ferr_n, ovr_n;

   logic [7:0] tx_data_e, rx_data_e;
   logic       tx_valid_e, tx_ready_e, uart_tx_e, rx_e, rx_valid_e, rx_ready_e;
   logic       perr_e, ferr_e, ovr_e;

   logic [6:0] tx_data_l, rx_data_l;
   logic       tx_valid_l, tx_ready_l, uart_tx_l, rx_valid_l, rx_ready_l;
   logic       perr_l, ferr_l, ovr_l;

   uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
      .clk(clk), .rst_n(rst_n), .uart_rx(rx_n), .uart_tx(uart_tx_n),
      .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
      .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
      .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .rx_overrun(ovr_n));

   uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .uart_rx(rx_e), .uart_tx(uart_tx_e),
      .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
      .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
      .rx_parity_err(perr_e), .rx_frame_err(ferr_e), .rx_overrun(ovr_e));

   uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_l (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_tx_l), .uart_tx(uart_tx_l),
      .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready_l),
      .rx_parity_err(perr_l), .rx_frame_err(ferr_l), .rx_overrun(ovr_l));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic valid_of(input int sel);
      case (sel)
         0:       return rx_valid_n;
         1:       return rx_valid_e;
         default: return rx_valid_l;
      endcase
   endfunction

   task automatic set_ready(input int sel, input logic v);
      case (sel)
         0:       rx_ready_n = v;
         1:       rx_ready_e = v;
         default: rx_ready_l = v;
      endcase
   endtask

   // Drive nbits of a frame (LSB first) onto the rx pin of dut_n (sel 0)
   // or dut_e (sel 1), one bit per CPB cycles, changing on falling edges.
   task automatic drive_bits(input int sel, input logic [15:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         if (sel == 0) rx_n = bits[i];
         else          rx_e = bits[i];
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   task automatic wait_rx(input int sel, input string tag);
      int k = 0;
      while (!valid_of(sel) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_valid"}, 32'(valid_of(sel)), 1);
   endtask

   task automatic accept_rx(input int sel, input string tag);
      @(negedge clk);
      set_ready(sel, 1'b1);
      @(negedge clk);
      set_ready(sel, 1'b0);
      check_eq({tag, "_acc_valid"}, 32'(valid_of(sel)), 0);
   endtask

   // Send one byte on dut_n and compare the whole line waveform against
   // the expected 8N1 frame, cycle by cycle.
   task automatic check_tx_frame(input logic [7:0] d, input string tag);
      logic [9:0] fr;
      int good[10];
      int low_ready;
      int idle_bad;
      fr        = {1'b1, d, 1'b0};
      low_ready = 0;
      idle_bad  = 0;
      for (int b = 0; b < 10; b++) good[b] = 0;
      @(negedge clk);
      tx_data_n  = d;
      tx_valid_n = 1'b1;
      for (int k = 0; k < 176; k++) begin
         @(negedge clk);
         if (k == 0) begin
            tx_valid_n = 1'b0;
            tx_data_n  = ~d;
         end
         if (k < 160 && uart_tx_n == fr[k / 16]) good[k / 16]++;
         if (k >= 160 && uart_tx_n != 1'b1) idle_bad++;
         if (!tx_ready_n) low_ready++;
      end
      $display("tx %s: sent 0x%02h, ready low for %0d cycles", tag, d, low_ready);
      for (int b = 0; b < 10; b++) begin
         check_eq($sformatf("%s_bit%0d", tag, b), good[b], 16);
      end
      check_eq({tag, "_ready_low"}, low_ready, 160);
      check_eq({tag, "_idle"}, idle_bad, 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] d7;
      int lb_bad;
      int lb_ok;

      rst_n      = 1'b0;
      rx_n       = 1'b1;
      rx_e       = 1'b1;
      tx_data_n  = '0;
      tx_valid_n = 1'b0;
      rx_ready_n = 1'b0;
      tx_data_e  = '0;
      tx_valid_e = 1'b0;
      rx_ready_e = 1'b0;
      tx_data_l  = '0;
      tx_valid_l = 1'b0;
      rx_ready_l = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_uart_tx", 32'(uart_tx_n), 1);
      check_eq("rst_tx_ready", 32'(tx_ready_n), 1);
      check_eq("rst_rx_valid", 32'(rx_valid_n), 0);
      check_eq("rst_rx_data", 32'(rx_data_n), 0);
      check_eq("rst_perr", 32'(perr_n), 0);
      check_eq("rst_ferr", 32'(ferr_n), 0);
      check_eq("rst_ovr", 32'(ovr_n), 0);
      check_eq("rst_uart_tx_e", 32'(uart_tx_e), 1);
      check_eq("rst_tx_ready_e", 32'(tx_ready_e), 1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // TX 8N1 waveform
      check_tx_frame(8'h4C, "tx4c");

      // Reset during data bit 3 of 0xF0 (bits 0..3 are zero)
      @(negedge clk);
      tx_data_n  = 8'hF0;
      tx_valid_n = 1'b1;
      @(negedge clk);
      tx_valid_n = 1'b0;
      repeat (71) @(negedge clk);
      check_eq("rst_mid_pre_tx", 32'(uart_tx_n), 0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_uart_tx", 32'(uart_tx_n), 1);
      check_eq("rst_mid_tx_ready", 32'(tx_ready_n), 1);
      $display("tx reset asserted mid-frame, uart_tx=%0d tx_ready=%0d", uart_tx_n, tx_ready_n);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_tx_frame(8'h7E, "tx7e");

      // RX 8E1: 0xA5 has four ones, so the even parity bit is 0
      drive_bits(1, {5'h1f, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
      wait_rx(1, "par_ok");
      $display("rx e: data=0x%02h perr=%0d ferr=%0d", rx_data_e, perr_e, ferr_e);
      check_eq("par_ok_data", 32'(rx_data_e), 32'hA5);
      check_eq("par_ok_perr", 32'(perr_e), 0);
      check_eq("par_ok_ferr", 32'(ferr_e), 0);
      accept_rx(1, "par_ok");

      drive_bits(1, {5'h1f, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
      wait_rx(1, "par_bad");
      $display("rx e: data=0x%02h perr=%0d ferr=%0d", rx_data_e, perr_e, ferr_e);
      check_eq("par_bad_data", 32'(rx_data_e), 32'hA5);
      check_eq("par_bad_perr", 32'(perr_e), 1);
      check_eq("par_bad_ferr", 32'(ferr_e), 0);
      accept_rx(1, "par_bad");

      // False start: 5-cycle glitch, then a real 0x33 frame
      @(negedge clk);
      rx_n = 1'b0;
      repeat (5) @(negedge clk);
      rx_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      $display("rx n: glitch, rx_valid=%0d", rx_valid_n);
      check_eq("fs_no_valid", 32'(rx_valid_n), 0);
      drive_bits(0, {6'h3f, 1'b1, 8'h33, 1'b0}, 10);
      wait_rx(0, "fs33");
      $display("rx n: data=0x%02h ferr=%0d ovr=%0d", rx_data_n, ferr_n, ovr_n);
      check_eq("fs33_data", 32'(rx_data_n), 32'h33);
      check_eq("fs33_ferr", 32'(ferr_n), 0);
      accept_rx(0, "fs33");

      // Frame error followed by a 40-bit break: exactly one delivery
      drive_bits(0, {6'h00, 1'b0, 8'h00, 1'b0}, 10);
      repeat (40 * CPB) @(negedge clk);
      rx_n = 1'b1;
      repeat (CPB) @(negedge clk);
      wait_rx(0, "brk");
      $display("rx n: data=0x%02h ferr=%0d ovr=%0d", rx_data_n, ferr_n, ovr_n);
      check_eq("brk_data", 32'(rx_data_n), 32'h00);
      check_eq("brk_ferr", 32'(ferr_n), 1);
      check_eq("brk_one_frame", 32'(ovr_n), 0);
      accept_rx(0, "brk");
      repeat (CPB) @(negedge clk);
      drive_bits(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10);
      wait_rx(0, "rx55");
      $display("rx n: data=0x%02h ferr=%0d ovr=%0d", rx_data_n, ferr_n, ovr_n);
      check_eq("rx55_data", 32'(rx_data_n), 32'h55);
      check_eq("rx55_ferr", 32'(ferr_n), 0);
      check_eq("rx55_ovr", 32'(ovr_n), 0);
      accept_rx(0, "rx55");

      // Overrun: second byte arrives while the first is still held
      drive_bits(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
      drive_bits(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
      repeat (CPB) @(negedge clk);
      $display("rx n: data=0x%02h valid=%0d ovr=%0d", rx_data_n, rx_valid_n, ovr_n);
      check_eq("ovr_valid", 32'(rx_valid_n), 1);
      check_eq("ovr_data", 32'(rx_data_n), 32'h11);
      check_eq("ovr_flag", 32'(ovr_n), 1);
      accept_rx(0, "ovr");
      check_eq("ovr_cleared", 32'(ovr_n), 0);

      // Loopback 7O2, 200 random bytes
      lb_bad = 0;
      lb_ok  = 0;
      for (int i = 0; i < 200; i++) begin
         int k;
         d7 = 7'($urandom_range(0, 127));
         k  = 0;
         while (!tx_ready_l && k < 400) begin
            @(negedge clk);
            k++;
         end
         tx_data_l  = d7;
         tx_valid_l = 1'b1;
         @(negedge clk);
         tx_valid_l = 1'b0;
         k = 0;
         while (!rx_valid_l && k < 400) begin
            @(negedge clk);
            k++;
         end
         $display("lb %0d: sent 0x%02h got 0x%02h valid=%0d perr=%0d ferr=%0d ovr=%0d",
                  i, d7, rx_data_l, rx_valid_l, perr_l, ferr_l, ovr_l);
         if (!rx_valid_l || rx_data_l !== d7 || perr_l || ferr_l || ovr_l) lb_bad++;
         else lb_ok++;
         if (rx_valid_l) begin
            @(negedge clk);
            rx_ready_l = 1'b1;
            @(negedge clk);
            rx_ready_l = 1'b0;
         end
      end
      check_eq("lb_bad", lb_bad, 0);
      check_eq("lb_ok", lb_ok, 200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
